// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - operand read, issue and write-back bundle for the RV32I register file
interface reg_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  read_en;
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic [DATA_WIDTH-1:0] src1_value;
    logic [DATA_WIDTH-1:0] src2_value;
    logic                  issue_req;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  write_req;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  stall;

    modport master (
        output read_en, rs1_addr, rs2_addr, issue_req, issue_rd,
               write_req, write_addr, write_data,
        input  src1_value, src2_value, stall
    );

    modport slave (
        input  read_en, rs1_addr, rs2_addr, issue_req, issue_rd,
               write_req, write_addr, write_data,
        output src1_value, src2_value, stall
    );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32 x 32 register file with registered read ports and RAW scoreboard
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    reg_file_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      pending_q, pending_d;
    logic [DATA_WIDTH-1:0] src1_q, src1_d;
    logic [DATA_WIDTH-1:0] src2_q, src2_d;

    logic                  wr_valid;
    logic                  wr_hit1, wr_hit2;
    logic                  hz1, hz2;
    logic                  stall;
    logic [DATA_WIDTH-1:0] val1, val2;

    assign wr_valid = bus.write_req && (bus.write_addr != '0);
    assign wr_hit1  = bus.write_req && (bus.write_addr == bus.rs1_addr);
    assign wr_hit2  = bus.write_req && (bus.write_addr == bus.rs2_addr);

    // A write-back landing this cycle resolves the hazard on its register.
    assign hz1   = (bus.rs1_addr != '0) && pending_q[bus.rs1_addr] && !wr_hit1;
    assign hz2   = (bus.rs2_addr != '0) && pending_q[bus.rs2_addr] && !wr_hit2;
    assign stall = bus.read_en && (hz1 || hz2);

    always_comb begin
        val1 = '0;
        val2 = '0;
        if (bus.rs1_addr != '0) begin
            val1 = wr_hit1 ? bus.write_data : regs_q[bus.rs1_addr];
        end
        if (bus.rs2_addr != '0) begin
            val2 = wr_hit2 ? bus.write_data : regs_q[bus.rs2_addr];
        end
    end

    always_comb begin
        src1_d = src1_q;
        src2_d = src2_q;
        if (bus.read_en && !stall) begin
            src1_d = val1;
            src2_d = val2;
        end
    end

    // Clear before set so a same-index issue keeps the newer producer outstanding.
    always_comb begin
        pending_d = pending_q;
        if (wr_valid) begin
            pending_d[bus.write_addr] = 1'b0;
        end
        if (bus.issue_req && (bus.issue_rd != '0) && !stall) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
        end else begin
            if (wr_valid) begin
                regs_q[bus.write_addr] <= bus.write_data;
            end
            pending_q <= pending_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
        end
    end

    assign bus.src1_value = src1_q;
    assign bus.src2_value = src2_q;
    assign bus.stall      = stall;
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized scoreboard bench for reg_file
module tb_reg_file;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        stall;
        logic [31:0] s1;
        logic [31:0] s2;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [31:0] m_mem  [32];
    bit          m_pend [32];
    logic [31:0] m_src1, m_src2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'd0;
            m_pend[i] = 1'b0;
        end
        m_src1 = 32'd0;
        m_src2 = 32'd0;
    endtask

    // Decoder/ALU traffic for one cycle; model expectations go on the scoreboard.
    task automatic step(input bit re, input logic [4:0] r1, input logic [4:0] r2,
                        input bit is, input logic [4:0] rd,
                        input bit wr, input logic [4:0] wa, input logic [31:0] wd);
        exp_t        e;
        bit          blocked;
        logic [31:0] v1, v2;
        @(posedge clk);
        #1;
        bus.read_en    = re;
        bus.rs1_addr   = r1;
        bus.rs2_addr   = r2;
        bus.issue_req  = is;
        bus.issue_rd   = rd;
        bus.write_req  = wr;
        bus.write_addr = wa;
        bus.write_data = wd;

        blocked = re && ((r1 != 0 && m_pend[r1] && !(wr && wa == r1)) ||
                         (r2 != 0 && m_pend[r2] && !(wr && wa == r2)));
        e.stall = blocked;
        e.s1    = m_src1;
        e.s2    = m_src2;
        exp_q.push_back(e);

        v1 = (r1 == 0) ? 32'd0 : (wr && wa == r1) ? wd : m_mem[r1];
        v2 = (r2 == 0) ? 32'd0 : (wr && wa == r2) ? wd : m_mem[r2];
        if (re && !blocked) begin
            m_src1 = v1;
            m_src2 = v2;
        end
        if (wr && wa != 0) begin
            m_mem[wa]  = wd;
            m_pend[wa] = 1'b0;
        end
        if (is && rd != 0 && !blocked) m_pend[rd] = 1'b1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", {31'd0, bus.stall}, {31'd0, e.stall});
            chk("src1_value", bus.src1_value, e.s1);
            chk("src2_value", bus.src2_value, e.s2);
        end
    end

    initial begin
        reset_n        = 1'b0;
        bus.read_en    = 1'b0;
        bus.rs1_addr   = '0;
        bus.rs2_addr   = '0;
        bus.issue_req  = 1'b0;
        bus.issue_rd   = '0;
        bus.write_req  = 1'b0;
        bus.write_addr = '0;
        bus.write_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", {31'd0, bus.stall}, 32'd0);
        chk("reset_src1", bus.src1_value, 32'd0);
        chk("reset_src2", bus.src2_value, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic write then registered read.
        step(0, 5'd0, 5'd0, 0, 5'd0, 1, 5'd16, 32'd100);
        step(0, 5'd0, 5'd0, 0, 5'd0, 1, 5'd18, 32'd80);
        step(1, 5'd16, 5'd18, 0, 5'd0, 0, 5'd0, 32'd0);
        idle();
        // x0 ignores writes.
        step(0, 5'd0, 5'd0, 0, 5'd0, 1, 5'd0, 32'hDEAD_BEEF);
        step(1, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 32'd0);
        idle();
        // Same-cycle write-first bypass.
        step(1, 5'd19, 5'd0, 0, 5'd0, 1, 5'd19, 32'd256);
        idle();
        // RAW hazard released by write-back in the same cycle.
        step(0, 5'd0, 5'd0, 1, 5'd19, 0, 5'd0, 32'd0);
        step(1, 5'd0, 5'd19, 0, 5'd0, 0, 5'd0, 32'd0);
        step(1, 5'd0, 5'd19, 0, 5'd0, 0, 5'd0, 32'd0);
        step(1, 5'd0, 5'd19, 0, 5'd0, 1, 5'd19, 32'h1234);
        idle();
        // Issue and write-back to the same index: set wins.
        step(0, 5'd0, 5'd0, 1, 5'd5, 1, 5'd5, 32'd7);
        step(1, 5'd5, 5'd0, 0, 5'd0, 0, 5'd0, 32'd0);
        step(1, 5'd5, 5'd0, 0, 5'd0, 0, 5'd0, 32'd0);
        step(1, 5'd5, 5'd0, 0, 5'd0, 1, 5'd5, 32'd9);
        idle();

        // Async reset while stalled.
        step(0, 5'd0, 5'd0, 1, 5'd7, 0, 5'd0, 32'd0);
        step(1, 5'd7, 5'd7, 0, 5'd0, 0, 5'd0, 32'd0);
        @(negedge clk);
        #2;
        chk("pre_reset_stall", {31'd0, bus.stall}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_stall", {31'd0, bus.stall}, 32'd0);
        chk("async_src1", bus.src1_value, 32'd0);
        chk("async_src2", bus.src2_value, 32'd0);
        exp_q.delete();
        model_reset();
        bus.read_en   = 1'b0;
        bus.issue_req = 1'b0;
        bus.write_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 5'd16, 5'd18, 0, 5'd0, 0, 5'd0, 32'd0);
        idle();

        // Random traffic over a small index range to keep hazards frequent.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                 $urandom());
        end
        idle();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
